// File: rtl/common_pkg.sv
// Shared types for the EX/MEM pipeline slice.
package common_pkg;

    // Memory access size; bit 2 marks a zero-extending (unsigned) load.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    // Occupancy state of the EX/MEM register.
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MC_WAIT = 2'b01,
        HOLD    = 2'b10
    } ex_mem_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count up on inc, stick at all-ones, zero on rst or clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with multi-cycle bubble injection, stall hold,
// flush, a multi-cycle watchdog and saturating performance counters.
module ex_mem_pipe
    import common_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned MAX_MC_CYCLES = 40,
    parameter int unsigned CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   alu_res,
    input  logic              insert_bubble,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_valid,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  mem_size_t         ex_mem_size,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic              mem_stall,
    input  logic              flush,
    input  logic              perf_clr,
    output logic              stall_ex,
    output logic              mem_valid,
    output logic [4:0]        mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output mem_size_t         mem_mem_size,
    output logic [XLEN-1:0]   mem_alu_res,
    output logic [XLEN-1:0]   mem_store_data,
    output logic [XLEN-1:0]   mem_pc,
    output logic              mc_busy,
    output logic              mc_timeout,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned MC_W = $clog2(MAX_MC_CYCLES + 1);

    ex_mem_state_t   r_state;
    ex_mem_state_t   w_state_nxt;
    logic [MC_W-1:0] r_mc_cnt;
    logic [MC_W-1:0] w_mc_cnt_nxt;
    logic            r_mc_timeout;

    logic            r_mem_valid;
    logic [4:0]      r_mem_rd;
    logic            r_mem_reg_write;
    logic            r_mem_mem_read;
    logic            r_mem_mem_write;
    mem_size_t       r_mem_mem_size;
    logic [XLEN-1:0] r_mem_alu_res;
    logic [XLEN-1:0] r_mem_store_data;
    logic [XLEN-1:0] r_mem_pc;

    logic            w_mc_req;
    logic            w_take_stall;
    logic            w_take_bubble;
    logic            w_take_capture;

    // Branch decode for this edge: flush > mem_stall > bubble > capture.
    assign w_mc_req       = ex_valid & insert_bubble;
    assign w_take_stall   = ~flush & mem_stall;
    assign w_take_bubble  = ~flush & ~mem_stall & w_mc_req;
    assign w_take_capture = ~flush & ~mem_stall & ~w_mc_req;

    assign stall_ex = mem_stall | w_mc_req;

    // Control bits: cleared on flush/bubble, held on stall, qualified by ex_valid on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid     <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_mem_mem_write <= 1'b0;
        end else if (flush || w_take_bubble) begin
            r_mem_valid     <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_mem_mem_write <= 1'b0;
        end else if (w_take_capture) begin
            r_mem_valid     <= ex_valid;
            r_mem_reg_write <= ex_reg_write & ex_valid;
            r_mem_mem_read  <= ex_mem_read  & ex_valid;
            r_mem_mem_write <= ex_mem_write & ex_valid;
        end
    end

    // Data fields only move on capture; otherwise they keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_rd         <= 5'd0;
            r_mem_mem_size   <= MEM_B;
            r_mem_alu_res    <= '0;
            r_mem_store_data <= '0;
            r_mem_pc         <= '0;
        end else if (w_take_capture) begin
            r_mem_rd         <= ex_rd;
            r_mem_mem_size   <= ex_mem_size;
            r_mem_alu_res    <= alu_res;
            r_mem_store_data <= ex_store_data;
            r_mem_pc         <= ex_pc;
        end
    end

    // Next multi-cycle count: clear when the op completes or is flushed, saturate at the limit.
    always_comb begin
        w_mc_cnt_nxt = r_mc_cnt;
        if (flush || !insert_bubble) begin
            w_mc_cnt_nxt = '0;
        end else if (ex_valid && (r_mc_cnt != MC_W'(MAX_MC_CYCLES))) begin
            w_mc_cnt_nxt = r_mc_cnt + MC_W'(1);
        end
    end

    // Watchdog count and sticky timeout flag, raised on the edge the count hits the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mc_cnt     <= '0;
            r_mc_timeout <= 1'b0;
        end else begin
            r_mc_cnt <= w_mc_cnt_nxt;
            if (w_mc_cnt_nxt == MC_W'(MAX_MC_CYCLES)) begin
                r_mc_timeout <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; flush always returns to RUN, a stall always parks in HOLD.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = RUN;
        end else if (mem_stall) begin
            w_state_nxt = HOLD;
        end else begin
            case (r_state)
                RUN:     w_state_nxt = w_mc_req ? MC_WAIT : RUN;
                MC_WAIT: w_state_nxt = insert_bubble ? MC_WAIT : RUN;
                HOLD:    w_state_nxt = w_mc_req ? MC_WAIT : RUN;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // Performance counters.
    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (w_take_bubble),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (w_take_stall),
        .count (stall_cnt)
    );

    assign mem_valid      = r_mem_valid;
    assign mem_rd         = r_mem_rd;
    assign mem_reg_write  = r_mem_reg_write;
    assign mem_mem_read   = r_mem_mem_read;
    assign mem_mem_write  = r_mem_mem_write;
    assign mem_mem_size   = r_mem_mem_size;
    assign mem_alu_res    = r_mem_alu_res;
    assign mem_store_data = r_mem_store_data;
    assign mem_pc         = r_mem_pc;
    assign mc_busy        = (r_state == MC_WAIT);
    assign mc_timeout     = r_mc_timeout;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe.
module tb_ex_mem_pipe;
    import common_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] alu_res;
    logic        insert_bubble;
    logic [31:0] ex_pc;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    mem_size_t   ex_mem_size;
    logic [31:0] ex_store_data;
    logic        mem_stall;
    logic        flush;
    logic        perf_clr;
    logic        stall_ex;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    mem_size_t   mem_mem_size;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_store_data;
    logic [31:0] mem_pc;
    logic        mc_busy;
    logic        mc_timeout;
    logic [31:0] bubble_cnt;
    logic [31:0] stall_cnt;

    int chk_cnt = 0;
    int err_cnt = 0;

    ex_mem_pipe #(.XLEN(32), .MAX_MC_CYCLES(40), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_res        (alu_res),
        .insert_bubble  (insert_bubble),
        .ex_pc          (ex_pc),
        .ex_valid       (ex_valid),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_size    (ex_mem_size),
        .ex_store_data  (ex_store_data),
        .mem_stall      (mem_stall),
        .flush          (flush),
        .perf_clr       (perf_clr),
        .stall_ex       (stall_ex),
        .mem_valid      (mem_valid),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_mem_size   (mem_mem_size),
        .mem_alu_res    (mem_alu_res),
        .mem_store_data (mem_store_data),
        .mem_pc         (mem_pc),
        .mc_busy        (mc_busy),
        .mc_timeout     (mc_timeout),
        .bubble_cnt     (bubble_cnt),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] res, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw,
                          input mem_size_t sz, input logic [31:0] sd, input logic [31:0] pc);
        ex_valid      = v;
        alu_res       = res;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_mem_size   = sz;
        ex_store_data = sd;
        ex_pc         = pc;
    endtask

    initial begin
        rst = 1'b1; insert_bubble = 1'b0; mem_stall = 1'b0; flush = 1'b0; perf_clr = 1'b0;
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, MEM_B, 32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_alu_res", 64'(mem_alu_res), 64'd0);
        chk("rst_mc_busy", 64'(mc_busy), 64'd0);
        chk("rst_timeout", 64'(mc_timeout), 64'd0);
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // ADD
        set_ex(1'b1, 32'h7, 5'd5, 1'b1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h100);
        #1 chk("add_stall_ex", 64'(stall_ex), 64'd0);
        tick();
        chk("add_mem_valid", 64'(mem_valid), 64'd1);
        chk("add_alu_res", 64'(mem_alu_res), 64'h7);
        chk("add_rd", 64'(mem_rd), 64'd5);
        chk("add_reg_write", 64'(mem_reg_write), 64'd1);
        chk("add_pc", 64'(mem_pc), 64'h100);
        chk("add_stall_ex2", 64'(stall_ex), 64'd0);

        // MUL: six bubble cycles then result
        set_ex(1'b1, 32'hBAD0, 5'd6, 1'b1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h104);
        insert_bubble = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 chk("mul_stall_ex", 64'(stall_ex), 64'd1);
            tick();
            chk("mul_bubble_valid", 64'(mem_valid), 64'd0);
            chk("mul_busy", 64'(mc_busy), 64'd1);
        end
        chk("mul_bubble_cnt", 64'(bubble_cnt), 64'd6);
        insert_bubble = 1'b0;
        alu_res = 32'h0000_0C35;
        #1 chk("mul_stall_ex_done", 64'(stall_ex), 64'd0);
        tick();
        chk("mul_alu_res", 64'(mem_alu_res), 64'hC35);
        chk("mul_mem_valid", 64'(mem_valid), 64'd1);
        chk("mul_rd", 64'(mem_rd), 64'd6);
        chk("mul_busy_fall", 64'(mc_busy), 64'd0);
        chk("mul_mc_cnt_clr", 64'(dut.r_mc_cnt), 64'd0);

        // Load held by mem_stall for three cycles
        set_ex(1'b1, 32'h1000, 5'd7, 1'b1, 1'b1, 1'b0, MEM_HU, 32'h0, 32'h40);
        tick();
        chk("ld_mem_read", 64'(mem_mem_read), 64'd1);
        set_ex(1'b1, 32'h2222, 5'd8, 1'b1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h44);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ld_stall_ex", 64'(stall_ex), 64'd1);
            tick();
            chk("ld_hold_alu", 64'(mem_alu_res), 64'h1000);
            chk("ld_hold_rd", 64'(mem_rd), 64'd7);
            chk("ld_hold_read", 64'(mem_mem_read), 64'd1);
            chk("ld_hold_pc", 64'(mem_pc), 64'h40);
            chk("ld_hold_size", 64'(mem_mem_size), 64'(MEM_HU));
            chk("ld_hold_valid", 64'(mem_valid), 64'd1);
        end
        chk("ld_stall_cnt", 64'(stall_cnt), 64'd3);
        mem_stall = 1'b0;
        tick();
        chk("ld_next_alu", 64'(mem_alu_res), 64'h2222);
        chk("ld_next_rd", 64'(mem_rd), 64'd8);
        chk("ld_next_read", 64'(mem_mem_read), 64'd0);
        chk("ld_stall_cnt_hold", 64'(stall_cnt), 64'd3);
        ex_valid = 1'b0;
        tick();
        chk("idle_valid", 64'(mem_valid), 64'd0);

        // DIV flushed on cycle 10
        set_ex(1'b1, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h80);
        insert_bubble = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("div_busy", 64'(mc_busy), 64'd1);
        chk("div_mc_cnt", 64'(dut.r_mc_cnt), 64'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0; insert_bubble = 1'b0; ex_valid = 1'b0;
        chk("div_flush_valid", 64'(mem_valid), 64'd0);
        chk("div_flush_busy", 64'(mc_busy), 64'd0);
        chk("div_flush_mc_cnt", 64'(dut.r_mc_cnt), 64'd0);
        chk("div_flush_timeout", 64'(mc_timeout), 64'd0);
        chk("div_bubble_cnt", 64'(bubble_cnt), 64'd15);

        // Watchdog: 45 consecutive bubble cycles
        ex_valid = 1'b1; insert_bubble = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            chk("wd_timeout", 64'(mc_timeout), (i >= 40) ? 64'd1 : 64'd0);
        end
        chk("wd_mc_cnt_sat", 64'(dut.r_mc_cnt), 64'd40);
        insert_bubble = 1'b0; ex_valid = 1'b0;
        tick();
        chk("wd_timeout_sticky", 64'(mc_timeout), 64'd1);
        chk("wd_bubble_cnt", 64'(bubble_cnt), 64'd60);

        // Store in MEM, then flush together with mem_stall
        set_ex(1'b1, 32'h80, 5'd0, 1'b0, 1'b0, 1'b1, MEM_B, 32'hDEAD, 32'hC0);
        tick();
        chk("st_mem_write", 64'(mem_mem_write), 64'd1);
        chk("st_mem_valid", 64'(mem_valid), 64'd1);
        ex_valid = 1'b0; mem_stall = 1'b1; flush = 1'b1;
        tick();
        mem_stall = 1'b0; flush = 1'b0;
        chk("fs_mem_write", 64'(mem_mem_write), 64'd0);
        chk("fs_mem_valid", 64'(mem_valid), 64'd0);
        chk("fs_stall_cnt", 64'(stall_cnt), 64'd3);
        chk("fs_busy", 64'(mc_busy), 64'd0);
        chk("fs_timeout_sticky", 64'(mc_timeout), 64'd1);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        chk("clr_bubble_cnt", 64'(bubble_cnt), 64'd0);
        chk("clr_stall_cnt", 64'(stall_cnt), 64'd0);

        // Reset in the middle of a multi-cycle op
        set_ex(1'b1, 32'h55, 5'd3, 1'b1, 1'b0, 1'b0, MEM_W, 32'h0, 32'hF0);
        tick();
        chk("pre_rst_alu", 64'(mem_alu_res), 64'h55);
        insert_bubble = 1'b1;
        tick(); tick();
        chk("pre_rst_busy", 64'(mc_busy), 64'd1);
        chk("pre_rst_bubble_cnt", 64'(bubble_cnt), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0; insert_bubble = 1'b0; ex_valid = 1'b0;
        chk("mid_rst_busy", 64'(mc_busy), 64'd0);
        chk("mid_rst_timeout", 64'(mc_timeout), 64'd0);
        chk("mid_rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        chk("mid_rst_alu", 64'(mem_alu_res), 64'd0);
        chk("mid_rst_mc_cnt", 64'(dut.r_mc_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
